// File: rtl/pixel_timing_gen_pkg.sv
// Shared counter width, default 1080p60 timing and a sync polarity helper
// for the pixel timing generator.
package pixel_timing_gen_pkg;

    localparam int COUNT_W         = 12;
    localparam int COUNT_MAX_TOTAL = 1 << COUNT_W;

    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_FP     = 88;
    localparam int DEF_H_SYNC   = 44;
    localparam int DEF_H_BP     = 148;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 36;

    typedef logic [COUNT_W-1:0] count_t;

    // Decodes of the count value that will be presented after the coming edge.
    typedef struct packed {
        logic active;
        logic sync;
        logic first;
        logic last;
    } axis_decode_t;

    function automatic logic sync_level(input logic in_window, input logic active_high);
        return active_high ? in_window : ~in_window;
    endfunction

endpackage

// File: rtl/pixel_timing_gen_timing_axis.sv
// One timing axis: a wrapping position counter plus active/sync window decode
// of the next count, so a registered decode lines up with the registered count.
module timing_axis
    import pixel_timing_gen_pkg::*;
#(
    parameter int   ACTIVE           = DEF_H_ACTIVE,
    parameter int   FP               = DEF_H_FP,
    parameter int   SYNC             = DEF_H_SYNC,
    parameter int   BP               = DEF_H_BP,
    parameter logic SYNC_ACTIVE_HIGH = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_step,
    output count_t       o_count,
    output logic         o_wrap,
    output axis_decode_t o_next
);

    localparam int     TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam count_t LAST       = count_t'(TOTAL - 1);
    localparam count_t ACTIVE_END = count_t'(ACTIVE);
    localparam count_t SYNC_START = count_t'(ACTIVE + FP);
    localparam count_t SYNC_END   = count_t'(ACTIVE + FP + SYNC);

    if (TOTAL > COUNT_MAX_TOTAL) begin : g_total_too_large
        $error("timing_axis: total count exceeds counter range");
    end
    if (BP < 1) begin : g_back_porch_too_small
        $error("timing_axis: back porch must be at least 1");
    end

    count_t r_count;
    count_t w_count_next;
    logic   w_at_last;
    logic   w_sync_window;

    assign w_at_last = (r_count == LAST);
    assign o_wrap    = i_step & w_at_last;

    // Reset parks the counter on its last position so the first step lands on 0.
    always_comb begin
        w_count_next = r_count;
        if (reset) begin
            w_count_next = LAST;
        end else if (i_step) begin
            w_count_next = w_at_last ? '0 : r_count + count_t'(1);
        end
    end

    assign w_sync_window = (w_count_next >= SYNC_START) && (w_count_next < SYNC_END);

    always_comb begin
        o_next        = '0;
        o_next.active = (w_count_next < ACTIVE_END);
        o_next.sync   = sync_level(w_sync_window, SYNC_ACTIVE_HIGH);
        o_next.first  = (w_count_next == '0);
        o_next.last   = (w_count_next == LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= LAST;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pixel_timing_gen.sv
// Raster timing generator: horizontal and vertical timing axes with registered
// sync, data-enable, line-end and frame-start strobes aligned to the counts.
module pixel_timing_gen
    import pixel_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE         = DEF_H_ACTIVE,
    parameter int H_FP             = DEF_H_FP,
    parameter int H_SYNC           = DEF_H_SYNC,
    parameter int H_BP             = DEF_H_BP,
    parameter int V_ACTIVE         = DEF_V_ACTIVE,
    parameter int V_FP             = DEF_V_FP,
    parameter int V_SYNC           = DEF_V_SYNC,
    parameter int V_BP             = DEF_V_BP,
    parameter int SYNC_ACTIVE_HIGH = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clockEnable,
    output logic [COUNT_W-1:0] hCount,
    output logic [COUNT_W-1:0] vCount,
    output logic               hSyncOut,
    output logic               vSyncOut,
    output logic               dataEnable,
    output logic               lineEnd,
    output logic               frameStart
);

    localparam logic POLARITY = (SYNC_ACTIVE_HIGH != 0);
    localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > COUNT_MAX_TOTAL || V_TOTAL > COUNT_MAX_TOTAL) begin : g_total_check
        $error("pixel_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
    end

    logic         w_h_wrap;
    logic         w_v_wrap;
    axis_decode_t w_h_next;
    axis_decode_t w_v_next;
    logic         w_unused;

    logic r_h_sync;
    logic r_v_sync;
    logic r_data_enable;
    logic r_line_end;
    logic r_frame_start;

    timing_axis #(
        .ACTIVE           (H_ACTIVE),
        .FP               (H_FP),
        .SYNC             (H_SYNC),
        .BP               (H_BP),
        .SYNC_ACTIVE_HIGH (POLARITY)
    ) u_h_axis (
        .clock   (clock),
        .reset   (reset),
        .i_step  (clockEnable),
        .o_count (hCount),
        .o_wrap  (w_h_wrap),
        .o_next  (w_h_next)
    );

    // The vertical axis steps once per line, on the enabled edge where hCount wraps.
    timing_axis #(
        .ACTIVE           (V_ACTIVE),
        .FP               (V_FP),
        .SYNC             (V_SYNC),
        .BP               (V_BP),
        .SYNC_ACTIVE_HIGH (POLARITY)
    ) u_v_axis (
        .clock   (clock),
        .reset   (reset),
        .i_step  (w_h_wrap),
        .o_count (vCount),
        .o_wrap  (w_v_wrap),
        .o_next  (w_v_next)
    );

    assign w_unused = &{1'b0, w_v_wrap, w_v_next.last};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_h_sync      <= sync_level(1'b0, POLARITY);
            r_v_sync      <= sync_level(1'b0, POLARITY);
            r_data_enable <= 1'b0;
            r_line_end    <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_h_sync      <= w_h_next.sync;
            r_v_sync      <= w_v_next.sync;
            r_data_enable <= w_h_next.active & w_v_next.active;
            r_line_end    <= w_h_next.last;
            r_frame_start <= w_h_next.first & w_v_next.first;
        end
    end

    assign hSyncOut   = r_h_sync;
    assign vSyncOut   = r_v_sync;
    assign dataEnable = r_data_enable;
    assign lineEnd    = r_line_end;
    assign frameStart = r_frame_start;

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Self-checking bench: a small raster model (plain modular arithmetic) checked
// every cycle against active-high and active-low instances, plus pinned literals.
module tb_pixel_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = 14, VT = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce  = 1'b0;
    logic [11:0] h_hi, v_hi, h_lo, v_lo;
    logic        hs_hi, vs_hi, de_hi, le_hi, fs_hi;
    logic        hs_lo, vs_lo, de_lo, le_lo, fs_lo;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;
    int m_h         = 0;
    int m_v         = 0;

    always #5 clk = ~clk;

    pixel_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE_HIGH(1)
    ) dut_hi (
        .clock(clk), .reset(rst), .clockEnable(ce),
        .hCount(h_hi), .vCount(v_hi), .hSyncOut(hs_hi), .vSyncOut(vs_hi),
        .dataEnable(de_hi), .lineEnd(le_hi), .frameStart(fs_hi)
    );

    pixel_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE_HIGH(0)
    ) dut_lo (
        .clock(clk), .reset(rst), .clockEnable(ce),
        .hCount(h_lo), .vCount(v_lo), .hSyncOut(hs_lo), .vSyncOut(vs_lo),
        .dataEnable(de_lo), .lineEnd(le_lo), .frameStart(fs_lo)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference raster position: reset parks at the last pixel of the last line.
    always @(posedge clk) begin
        if (rst) begin
            m_h <= HT - 1;
            m_v <= VT - 1;
        end else if (ce) begin
            m_h <= (m_h + 1) % HT;
            if (m_h == HT - 1) m_v <= (m_v + 1) % VT;
        end
    end

    always @(negedge clk) begin
        bit e_de, e_hs, e_vs, e_le, e_fs;
        if (chk_en) begin
            e_de = (m_h < HA) && (m_v < VA);
            e_hs = (m_h >= HA + HF) && (m_h < HA + HF + HS);
            e_vs = (m_v >= VA + VF) && (m_v < VA + VF + VS);
            e_le = (m_h == HT - 1);
            e_fs = (m_h == 0) && (m_v == 0);
            check("hi_hCount", 32'(h_hi), 32'(m_h));
            check("hi_vCount", 32'(v_hi), 32'(m_v));
            check("hi_hSync", 32'(hs_hi), 32'(e_hs));
            check("hi_vSync", 32'(vs_hi), 32'(e_vs));
            check("hi_dataEnable", 32'(de_hi), 32'(e_de));
            check("hi_lineEnd", 32'(le_hi), 32'(e_le));
            check("hi_frameStart", 32'(fs_hi), 32'(e_fs));
            check("lo_hCount", 32'(h_lo), 32'(m_h));
            check("lo_vCount", 32'(v_lo), 32'(m_v));
            check("lo_hSync", 32'(hs_lo), 32'(!e_hs));
            check("lo_vSync", 32'(vs_lo), 32'(!e_vs));
            check("lo_dataEnable", 32'(de_lo), 32'(e_de));
            check("lo_lineEnd", 32'(le_lo), 32'(e_le));
            check("lo_frameStart", 32'(fs_lo), 32'(e_fs));
        end
    end

    initial begin
        int fs_n, last_fs, le_n, hs_n, hs_lo_n, vs_n, vs_lo_n, hs_bad, vs_bad, de_bad;
        int rises, rise0, rise1;
        bit prev_fs, found;

        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_hCount", 32'(h_hi), 32'd13);
        check("reset_vCount", 32'(v_hi), 32'd6);
        check("reset_dataEnable", 32'(de_hi), 32'd0);
        check("reset_lineEnd", 32'(le_hi), 32'd1);
        check("reset_frameStart", 32'(fs_hi), 32'd0);
        check("reset_hSync_hi", 32'(hs_hi), 32'd0);
        check("reset_hSync_lo", 32'(hs_lo), 32'd1);
        check("reset_vSync_lo", 32'(vs_lo), 32'd1);
        $display("phase reset: done");

        rst = 1'b0;
        ce  = 1'b1;
        @(negedge clk);
        check("first_hCount", 32'(h_hi), 32'd0);
        check("first_vCount", 32'(v_hi), 32'd0);
        check("first_dataEnable", 32'(de_hi), 32'd1);
        check("first_frameStart", 32'(fs_hi), 32'd1);

        fs_n = 0; last_fs = 0; le_n = 0; hs_n = 0; hs_lo_n = 0;
        vs_n = 0; vs_lo_n = 0; hs_bad = 0; vs_bad = 0; de_bad = 0;
        for (int c = 1; c <= 2 * HT * VT; c++) begin
            @(negedge clk);
            if (fs_hi) begin fs_n++; last_fs = c; end
            if (le_hi) le_n++;
            if (hs_hi) begin hs_n++; if (h_hi < 12'd10 || h_hi > 12'd11) hs_bad++; end
            if (!hs_lo) hs_lo_n++;
            if (vs_hi) begin vs_n++; if (v_hi != 12'd5) vs_bad++; end
            if (!vs_lo) vs_lo_n++;
            if (de_hi && v_hi >= 12'd4) de_bad++;
        end
        check("frame_starts_in_196", 32'(fs_n), 32'd2);
        check("last_frame_start_cycle", 32'(last_fs), 32'd196);
        check("line_ends_in_196", 32'(le_n), 32'd14);
        check("hsync_pixels_hi", 32'(hs_n), 32'd28);
        check("hsync_pixels_lo", 32'(hs_lo_n), 32'd28);
        check("hsync_outside_10_11", 32'(hs_bad), 32'd0);
        check("vsync_pixels_hi", 32'(vs_n), 32'd28);
        check("vsync_pixels_lo", 32'(vs_lo_n), 32'd28);
        check("vsync_outside_line5", 32'(vs_bad), 32'd0);
        check("de_in_vblank", 32'(de_bad), 32'd0);
        $display("phase continuous: done");

        rises = 0; rise0 = 0; rise1 = 0; prev_fs = fs_hi;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (fs_hi && !prev_fs) begin
                if (rises == 0) rise0 = c;
                else if (rises == 1) rise1 = c;
                rises++;
            end
            prev_fs = fs_hi;
            ce = ~ce;
        end
        check("toggle_frame_rises", 32'(rises >= 2), 32'd1);
        check("toggle_frame_period", 32'(rise1 - rise0), 32'd196);
        $display("phase toggle enable: done");

        ce = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (m_h == 5 && m_v == 2) found = 1'b1;
        end
        check("reach_h5_v2", 32'(found), 32'd1);
        check("at_h5", 32'(h_hi), 32'd5);
        rst = 1'b1;
        ce  = 1'b0;
        @(negedge clk);
        check("midreset_hCount", 32'(h_hi), 32'd13);
        check("midreset_vCount", 32'(v_hi), 32'd6);
        check("midreset_dataEnable", 32'(de_hi), 32'd0);
        check("midreset_lineEnd", 32'(le_hi), 32'd1);
        rst = 1'b0;
        ce  = 1'b1;
        $display("phase mid-frame reset: done");

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ce  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("phase random: done");

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_timing_gen.md
PIXEL_TIMING_GEN -- requirements
Module: pixel_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 1920, visible pixels per line.
REQ-002 Parameter H_FP, default 88, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 44, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 148, horizontal back porch in pixels; SHALL be >= 1.
REQ-005 Parameter V_ACTIVE, default 1080, visible lines per frame.
REQ-006 Parameter V_FP, default 4, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 5, vertical sync width in lines.
REQ-008 Parameter V_BP, default 36, vertical back porch in lines; SHALL be >= 1.
REQ-009 Parameter SYNC_ACTIVE_HIGH, default 1, sync polarity; 1 means active level is 1, 0 means active level is 0.
REQ-010 clock  input  1  sole clock; every register is on its rising edge.
REQ-011 reset  input  1  synchronous, active-high reset.
REQ-012 clockEnable  input  1  pixel advance qualifier; when 0, all state holds.
REQ-013 hCount  output  12  current pixel index within the line.
REQ-014 vCount  output  12  current line index within the frame.
REQ-015 hSyncOut  output  1  horizontal sync, polarity per SYNC_ACTIVE_HIGH.
REQ-016 vSyncOut  output  1  vertical sync, polarity per SYNC_ACTIVE_HIGH.
REQ-017 dataEnable  output  1  high when hCount < H_ACTIVE and vCount < V_ACTIVE.
REQ-018 lineEnd  output  1  high while hCount == H_TOTAL-1.
REQ-019 frameStart  output  1  high while hCount == 0 and vCount == 0.

Function
REQ-020 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; both SHALL be <= 4096, else elaboration error.
REQ-021 All outputs SHALL be registered; no output driven combinationally from inputs.
REQ-022 Every decoded output SHALL describe the hCount/vCount pair presented in the same cycle (decodes computed from next-state counts, zero relative latency).
REQ-023 On an edge with clockEnable=1: hCount increments; at H_TOTAL-1 it wraps to 0.
REQ-024 vCount increments only on the edge where hCount wraps; at V_TOTAL-1 it wraps to 0 simultaneously with hCount.
REQ-025 On an edge with clockEnable=0, all counters and outputs SHALL hold their values.
REQ-026 hSyncOut is active for H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC; inactive otherwise.
REQ-027 vSyncOut is active for V_ACTIVE+V_FP <= vCount < V_ACTIVE+V_FP+V_SYNC, on whole lines (changes only with hCount wrap).
REQ-028 lineEnd and frameStart SHALL each be high for exactly one enabled pixel per line/frame respectively.
REQ-029 Counter arithmetic SHALL be 12-bit unsigned; counts never exceed H_TOTAL-1 / V_TOTAL-1.

Reset
REQ-030 While reset=1 (takes priority over clockEnable): hCount = H_TOTAL-1, vCount = V_TOTAL-1, dataEnable=0, hSyncOut and vSyncOut inactive, lineEnd=1, frameStart=0.
REQ-031 The first enabled edge after reset deasserts SHALL present hCount=0, vCount=0, dataEnable=1, frameStart=1.
REQ-032 Reset asserted mid-frame SHALL take effect on the next edge, regardless of clockEnable.

Structure
REQ-033 Shared package SHALL hold the 12-bit count width constant and the default 1080p60 timing constants.
REQ-034 One sub-module, timing_axis (wrap counter plus sync/active window decode), SHALL be instantiated twice: horizontal and vertical, with the vertical instance advanced by the horizontal wrap.

Verification (bench timing H 8/2/2/2, V 4/1/1/1, SYNC_ACTIVE_HIGH=1; H_TOTAL=14, V_TOTAL=7)
REQ-035 Release reset, clockEnable=1 -> cycle 1: hCount=0, vCount=0, dataEnable=1, frameStart=1; hSyncOut=1 exactly at hCount 10..11.
REQ-036 Run 98 enabled cycles -> hCount and vCount both wrap to 0 together; frameStart recurs every 98 enabled cycles.
REQ-037 Check vertical window -> vSyncOut=1 for all 14 pixels of vCount=5 only; dataEnable=0 whenever vCount >= 4.
REQ-038 Toggle clockEnable 1/0 alternately -> counts advance every second cycle; frame period 196 cycles; outputs held while disabled.
REQ-039 Assert reset at hCount=5, vCount=2 with clockEnable=0 -> next edge hCount=13, vCount=6, dataEnable=0, lineEnd=1.
REQ-040 SYNC_ACTIVE_HIGH=0 -> hSyncOut=0 only at hCount 10..11; vSyncOut=0 only on line 5.
